// File: rtl/popcnt_vector_gen.sv
`timescale 1ns/1ps
// popcnt_vector_gen
// Stimulus source for the popcount units. A request with weight k streams every
// WIDTH-bit word that has exactly k ones, in ascending order, over a registered
// valid/ready interface. Each next word is built with a Gosper next-combination
// step. When the run ends, finishes, or is aborted, the block returns to idle.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready/req_k      request handshake carrying weight k
//   abort                          synchronous cancel of the current run
//   vec_valid/vec_ready/vec_data   generated word stream
//   vec_last                       final word of the run
//   done, bad_req                  one-cycle status pulses
//   word_cnt                       saturating count of accepted words
//   err                            sticky self-check error
// Optional feature: define POPGEN_SELFCHECK_EN to build a popcount checker on
// every beat. Without it, err is tied to 0.
module popcnt_vector_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CW-1:0]    req_k,
  input  logic             abort,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_data,
  output logic             vec_last,
  output logic             done,
  output logic             bad_req,
  output logic [31:0]      word_cnt,
  output logic             err
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_data_q, vec_data_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             vec_valid_q, vec_valid_d;
  logic             vec_last_q, vec_last_d;
  logic             done_q, done_d;
  logic             bad_req_q, bad_req_d;
  logic             req_ready_q, req_ready_d;
  logic [31:0]      word_cnt_q, word_cnt_d;

  logic             accept;
  logic             beat;
  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] next_word;

  // Word with the n lowest bits set; safe for n == WIDTH without a wide shift.
  function automatic logic [WIDTH-1:0] mask_lo(input int unsigned n);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WIDTH; i++) m[i] = (i < n);
    return m;
  endfunction

  // Priority encoder: index of the lowest set bit.
  function automatic int unsigned ctz(input logic [WIDTH-1:0] v);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign accept = req_valid && req_ready_q;
  assign beat   = vec_valid_q && vec_ready;

  // Gosper step. The ripple cannot overflow because it is only used on non-last words.
  assign low_bit   = vec_data_q & (~vec_data_q + WIDTH'(1));
  assign ripple    = vec_data_q + low_bit;
  assign next_word = ripple | (((ripple ^ vec_data_q) >> 2) >> ctz(low_bit));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    vec_data_d  = vec_data_q;
    top_d       = top_q;
    vec_valid_d = vec_valid_q;
    vec_last_d  = vec_last_q;
    word_cnt_d  = word_cnt_q;
    done_d      = 1'b0;
    bad_req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_cnt_d = '0;
          if (32'(req_k) > WIDTH) begin
            bad_req_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d     = RUN;
            vec_valid_d = 1'b1;
            vec_data_d  = mask_lo(32'(req_k));
            top_d       = ~mask_lo(WIDTH - 32'(req_k));
            vec_last_d  = (mask_lo(32'(req_k)) == ~mask_lo(WIDTH - 32'(req_k)));
          end
        end
      end
      RUN: begin
        if (beat && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 32'd1;
        if (abort || (beat && vec_last_q)) begin
          state_d     = IDLE;
          vec_valid_d = 1'b0;
          vec_last_d  = 1'b0;
          done_d      = 1'b1;
        end else if (beat) begin
          vec_data_d = next_word;
          vec_last_d = (next_word == top_q);
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_data_q  <= '0;
      top_q       <= '0;
      vec_valid_q <= 1'b0;
      vec_last_q  <= 1'b0;
      done_q      <= 1'b0;
      bad_req_q   <= 1'b0;
      req_ready_q <= 1'b1;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vec_data_q  <= vec_data_d;
      top_q       <= top_d;
      vec_valid_q <= vec_valid_d;
      vec_last_q  <= vec_last_d;
      done_q      <= done_d;
      bad_req_q   <= bad_req_d;
      req_ready_q <= req_ready_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign vec_last  = vec_last_q;
  assign done      = done_q;
  assign bad_req   = bad_req_q;
  assign word_cnt  = word_cnt_q;

`ifdef POPGEN_SELFCHECK_EN
  logic [CW-1:0] k_q, k_d;
  logic          err_q, err_d;

  // Bit-sum of the word; synthesis reduces it to an adder tree.
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < WIDTH; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  // Latch k at accept; flag any beat whose word weight differs from it.
  always_comb begin
    k_d   = k_q;
    err_d = err_q;
    if (accept) k_d = req_k;
    if (beat && (popcount(vec_data_q) != k_q)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      err_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt_vector_gen.sv
`timescale 1ns/1ps
module tb_popcnt_vector_gen;

  localparam int unsigned W   = 32;
  localparam int unsigned KW  = 6;
  localparam int unsigned WS  = 8;
  localparam int unsigned KWS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, abort, vec_valid, vec_ready, vec_last;
  logic          done, bad_req, err;
  logic [KW-1:0] req_k;
  logic [W-1:0]  vec_data;
  logic [31:0]   word_cnt;

  logic           req_valid_s, req_ready_s, abort_s, vec_valid_s, vec_ready_s, vec_last_s;
  logic           done_s, bad_req_s, err_s;
  logic [KWS-1:0] req_k_s;
  logic [WS-1:0]  vec_data_s;
  logic [31:0]    word_cnt_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  popcnt_vector_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_k(req_k), .abort(abort), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_last(vec_last), .done(done), .bad_req(bad_req),
    .word_cnt(word_cnt), .err(err)
  );

  popcnt_vector_gen #(.WIDTH(WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_s), .req_ready(req_ready_s),
    .req_k(req_k_s), .abort(abort_s), .vec_valid(vec_valid_s), .vec_ready(vec_ready_s),
    .vec_data(vec_data_s), .vec_last(vec_last_s), .done(done_s), .bad_req(bad_req_s),
    .word_cnt(word_cnt_s), .err(err_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: smallest integer above x with exactly k ones (small words only).
  function automatic logic [31:0] next_ref(input logic [31:0] x, input int k);
    logic [31:0] y;
    y = x + 32'd1;
    while ($countones(y) != k) y = y + 32'd1;
    return y;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    int          idx;
    int          beats;
    int          cyc;

    rst_n = 1'b0; req_valid = 1'b0; req_k = '0; abort = 1'b0; vec_ready = 1'b0;
    req_valid_s = 1'b0; req_k_s = '0; abort_s = 1'b0; vec_ready_s = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_vec_valid", vec_valid, 0);
    check("rst_vec_last", vec_last, 0);
    check("rst_vec_data", vec_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_done", done, 0);
    check("rst_bad_req", bad_req, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // k=2, always ready: 496 words ending at 0xC0000000
    req_valid = 1'b1; req_k = 6'd2; vec_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("k2_req_ready_run", req_ready, 0);
    check("k2_cnt_start", word_cnt, 0);
    idx = 0;
    for (int hi = 1; hi < 32; hi++) begin
      for (int lo = 0; lo < hi; lo++) begin
        exp = (32'd1 << hi) | (32'd1 << lo);
        check("k2_valid", vec_valid, 1);
        check("k2_data", vec_data, exp);
        check("k2_last", vec_last, (idx == 495));
        idx++;
        @(negedge clk);
      end
    end
    check("k2_end_valid", vec_valid, 0);
    check("k2_end_done", done, 1);
    check("k2_end_cnt", word_cnt, 496);
    check("k2_end_req_ready", req_ready, 1);
    @(negedge clk);
    check("k2_done_pulse", done, 0);
    check("k2_cnt_hold", word_cnt, 496);

    // k=0: single zero word
    req_valid = 1'b1; req_k = 6'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("k0_valid", vec_valid, 1);
    check("k0_data", vec_data, 0);
    check("k0_last", vec_last, 1);
    @(negedge clk);
    check("k0_end_valid", vec_valid, 0);
    check("k0_done", done, 1);
    check("k0_cnt", word_cnt, 1);

    // k=32: single all-ones word
    req_valid = 1'b1; req_k = 6'd32;
    @(negedge clk);
    req_valid = 1'b0;
    check("k32_valid", vec_valid, 1);
    check("k32_data", vec_data, 32'hFFFF_FFFF);
    check("k32_last", vec_last, 1);
    @(negedge clk);
    check("k32_end_valid", vec_valid, 0);
    check("k32_done", done, 1);
    check("k32_cnt", word_cnt, 1);

    // k=33: rejected, bad_req and done together, counter cleared
    req_valid = 1'b1; req_k = 6'd33;
    @(negedge clk);
    req_valid = 1'b0;
    check("k33_bad_req", bad_req, 1);
    check("k33_done", done, 1);
    check("k33_valid", vec_valid, 0);
    check("k33_req_ready", req_ready, 1);
    check("k33_cnt", word_cnt, 0);
    @(negedge clk);
    check("k33_bad_req_pulse", bad_req, 0);
    check("k33_valid_after", vec_valid, 0);

    // k=3 with random back-pressure, then abort while stalled
    vec_ready = 1'b0;
    req_valid = 1'b1; req_k = 6'd3;
    @(negedge clk);
    req_valid = 1'b0;
    exp = 32'h7; beats = 0; cyc = 0;
    while (beats < 40 && cyc < 400) begin
      check("k3_valid", vec_valid, 1);
      check("k3_data", vec_data, exp);
      vec_ready = 1'($urandom_range(0, 1));
      if (vec_ready) begin
        beats++;
        exp = next_ref(exp, 3);
      end
      @(negedge clk);
      cyc++;
    end
    check("k3_beat_budget", beats, 40);
    vec_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("k3_abort_done", done, 1);
    check("k3_abort_valid", vec_valid, 0);
    check("k3_abort_cnt", word_cnt, beats);
    check("k3_abort_req_ready", req_ready, 1);

    // Abort after 10 beats at full rate
    req_valid = 1'b1; req_k = 6'd5; vec_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("ab10_valid_before", vec_valid, 1);
    abort = 1'b1; vec_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("ab10_done", done, 1);
    check("ab10_valid", vec_valid, 0);
    check("ab10_cnt", word_cnt, 10);

    // Abort in idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_done", done, 0);
    check("idle_abort_ready", req_ready, 1);

    // Reset asserted mid-run
    req_valid = 1'b1; req_k = 6'd2; vec_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_running", vec_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", vec_valid, 0);
    check("mid_rst_data", vec_data, 0);
    check("mid_rst_last", vec_last, 0);
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    check("mid_rst_idle_valid", vec_valid, 0);

`ifdef POPGEN_SELFCHECK_EN
    // Corrupt one beat; err must rise and stay set
    check("sc_err_clean", err, 0);
    req_valid = 1'b1; req_k = 6'd2; vec_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    force dut.vec_data_q = 32'h7;
    vec_ready = 1'b1;
    @(negedge clk);
    release dut.vec_data_q;
    vec_ready = 1'b0;
    check("sc_err_set", err, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("sc_err_sticky", err, 1);
`else
    check("no_sc_err", err, 0);
`endif

    // WIDTH=8, k=4: 70 ascending words ending at 0xF0
    req_valid_s = 1'b1; req_k_s = 4'd4; vec_ready_s = 1'b1;
    @(negedge clk);
    req_valid_s = 1'b0;
    exp = 32'h0F;
    for (int i = 0; i < 70; i++) begin
      check("w8_valid", vec_valid_s, 1);
      check("w8_data", vec_data_s, exp);
      check("w8_last", vec_last_s, (i == 69));
      if (i == 69) check("w8_final_word", vec_data_s, 8'hF0);
      if (i < 69) exp = next_ref(exp, 4);
      @(negedge clk);
    end
    check("w8_end_valid", vec_valid_s, 0);
    check("w8_done", done_s, 1);
    check("w8_cnt", word_cnt_s, 70);
    check("w8_err", err_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
